// File: rtl/fractcam_pkg.sv
// Shared definitions for the FracTCAM update engine and the array's reference model.
package fractcam_pkg;

  localparam int FRAC_LUT_ADDR_W  = 5;
  localparam int FRAC_LUT_ENTRIES = 32;
  localparam int FRAC_GROUP       = 8;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP,
    ST_DONE
  } wr_state_e;

  // LUTRAM content bit for one 5-bit column of one entry at sweep address a.
  function automatic logic frac_rule_bit(
    input logic [FRAC_LUT_ADDR_W-1:0] a,
    input logic [FRAC_LUT_ADDR_W-1:0] value5,
    input logic [FRAC_LUT_ADDR_W-1:0] mask5,
    input logic                       en
  );
    return en & (((a ^ value5) & mask5) == '0);
  endfunction

endpackage

// File: rtl/fractcam_rule_gen.sv
// Combinational rule bits for the 8 entries of one row group at sweep address addr.
module fractcam_rule_gen
  import fractcam_pkg::*;
#(
  parameter  int TCAM_WIDTH = 5,
  localparam int NCOL       = TCAM_WIDTH / FRAC_LUT_ADDR_W
) (
  input  logic [FRAC_LUT_ADDR_W-1:0]       addr,
  input  logic [FRAC_GROUP*TCAM_WIDTH-1:0] grp_value,
  input  logic [FRAC_GROUP*TCAM_WIDTH-1:0] grp_mask,
  input  logic [FRAC_GROUP-1:0]            grp_en,
  output logic [NCOL*FRAC_GROUP-1:0]       rules
);

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    for (genvar e = 0; e < FRAC_GROUP; e++) begin : g_ent
      assign rules[c*FRAC_GROUP+e] = frac_rule_bit(
        addr,
        grp_value[e*TCAM_WIDTH + c*FRAC_LUT_ADDR_W +: FRAC_LUT_ADDR_W],
        grp_mask [e*TCAM_WIDTH + c*FRAC_LUT_ADDR_W +: FRAC_LUT_ADDR_W],
        grp_en[e]);
    end
  end

endmodule

// File: rtl/fractcam_writer.sv
// FracTCAM update engine: shadows every entry, sweeps 32 LUT addresses per group
// rewrite, flushes the array after reset, and muxes the array search key.
module fractcam_writer
  import fractcam_pkg::*;
#(
  parameter  int TCAM_WIDTH = 5,
  parameter  int TCAM_DEPTH = 64,
  localparam int IDX_W      = $clog2(TCAM_DEPTH)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            s_wr_valid,
  output logic                                            s_wr_ready,
  input  logic [IDX_W-1:0]                                s_wr_index,
  input  logic [TCAM_WIDTH-1:0]                           s_wr_value,
  input  logic [TCAM_WIDTH-1:0]                           s_wr_mask,
  input  logic                                            s_wr_entry_en,
  output logic                                            wr_done,
  output logic                                            wr_err,
  output logic                                            busy,
  input  logic [TCAM_WIDTH-1:0]                           lookup_key,
  output logic [TCAM_WIDTH-1:0]                           tcam_search_key,
  output logic [TCAM_DEPTH/FRAC_GROUP-1:0]                tcam_wr_enable,
  output logic [TCAM_WIDTH*FRAC_GROUP/FRAC_LUT_ADDR_W-1:0] tcam_rules
);

  localparam int NCOL = TCAM_WIDTH / FRAC_LUT_ADDR_W;
  localparam int NG   = TCAM_DEPTH / FRAC_GROUP;
  localparam int GW   = IDX_W - 3;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(TCAM_DEPTH);
  localparam logic [FRAC_LUT_ADDR_W-1:0] LAST_A = FRAC_LUT_ADDR_W'(FRAC_LUT_ENTRIES - 1);

  wr_state_e                  state, state_n;
  logic [FRAC_LUT_ADDR_W-1:0] cnt, cnt_n;
  logic                       arm;
  logic [GW-1:0]              grp;
  logic                       err;
  logic                       hs, in_range;

  logic [TCAM_WIDTH-1:0] sh_value [TCAM_DEPTH];
  logic [TCAM_WIDTH-1:0] sh_mask  [TCAM_DEPTH];
  logic [TCAM_DEPTH-1:0] sh_en;

  logic [FRAC_GROUP*TCAM_WIDTH-1:0] grp_value, grp_mask;
  logic [FRAC_GROUP-1:0]            grp_en;
  logic [NCOL*FRAC_GROUP-1:0]       rules_w;

  assign hs       = s_wr_valid & s_wr_ready;
  assign in_range = {1'b0, s_wr_index} < DEPTH_L;

  // arm holds off the first flush address by one clock so strobes start on the
  // first edge after reset release.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_FLUSH: begin
        if (arm)                cnt_n = '0;
        else if (cnt == LAST_A) state_n = ST_IDLE;
        else                    cnt_n = cnt + 1'b1;
      end
      ST_IDLE:  if (hs) state_n = ST_LOAD;
      ST_LOAD: begin
        if (err) state_n = ST_DONE;
        else begin
          state_n = ST_SWEEP;
          cnt_n   = '0;
        end
      end
      ST_SWEEP: begin
        if (cnt == LAST_A) state_n = ST_DONE;
        else               cnt_n = cnt + 1'b1;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_FLUSH;
    endcase
  end

  always_comb begin
    logic [IDX_W-1:0] gidx;
    grp_value = '0;
    grp_mask  = '0;
    grp_en    = '0;
    gidx      = '0;
    for (int e = 0; e < FRAC_GROUP; e++) begin
      gidx = {grp, e[2:0]};
      grp_value[e*TCAM_WIDTH +: TCAM_WIDTH] = sh_value[gidx];
      grp_mask [e*TCAM_WIDTH +: TCAM_WIDTH] = sh_mask[gidx];
      grp_en[e] = sh_en[gidx];
    end
  end

  fractcam_rule_gen #(.TCAM_WIDTH(TCAM_WIDTH)) u_rule_gen (
    .addr      (cnt_n),
    .grp_value (grp_value),
    .grp_mask  (grp_mask),
    .grp_en    (grp_en),
    .rules     (rules_w)
  );

  // Value/mask are don't-care while en=0, so only en needs a reset.
  always_ff @(posedge clk) begin
    if (hs && in_range) begin
      sh_value[s_wr_index] <= s_wr_value;
      sh_mask[s_wr_index]  <= s_wr_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_FLUSH;
      cnt             <= '0;
      arm             <= 1'b1;
      grp             <= '0;
      err             <= 1'b0;
      sh_en           <= '0;
      s_wr_ready      <= 1'b0;
      wr_done         <= 1'b0;
      wr_err          <= 1'b0;
      busy            <= 1'b1;
      tcam_search_key <= '0;
      tcam_wr_enable  <= '0;
      tcam_rules      <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      arm   <= 1'b0;
      if (hs) begin
        grp <= s_wr_index[IDX_W-1:3];
        err <= ~in_range;
        if (in_range) sh_en[s_wr_index] <= s_wr_entry_en;
      end
      // Outputs decode the state being entered, so they line up with it cycle for cycle.
      s_wr_ready <= (state_n == ST_IDLE);
      busy       <= (state_n == ST_FLUSH) || (state_n == ST_LOAD) || (state_n == ST_SWEEP);
      wr_done    <= (state_n == ST_DONE);
      wr_err     <= (state_n == ST_DONE) & err;
      tcam_wr_enable <= (state_n == ST_FLUSH) ? '1 :
                        (state_n == ST_SWEEP) ? (NG'(1) << grp) : '0;
      tcam_rules <= (state_n == ST_SWEEP) ? rules_w : '0;
      tcam_search_key <= ((state_n == ST_FLUSH) || (state_n == ST_SWEEP)) ?
                         {NCOL{cnt_n}} : lookup_key;
    end
  end

endmodule

// File: tb/tb_fractcam_writer.sv
// Directed bench for fractcam_writer: flush, exact/wildcard/delete writes,
// backpressure with out-of-range drop, and reset during a sweep.
module tb_fractcam_writer;

  logic clk = 1'b0;
  logic rst;

  logic       wr_valid, wr_ready, wr_en, wr_done, wr_err, busy;
  logic [5:0] wr_index;
  logic [4:0] wr_value, wr_mask, lookup_key, skey;
  logic [7:0] wen, rules;

  logic       b_valid, b_ready, b_en, b_done, b_err, b_busy;
  logic [5:0] b_index;
  logic [4:0] b_value, b_mask, b_lookup, b_skey;
  logic [4:0] b_wen;
  logic [7:0] b_rules;

  int total = 0;
  int bad   = 0;

  logic [7:0] wen_log   [0:40];
  logic [7:0] rules_log [0:40];
  logic [4:0] key_log   [0:40];
  logic       done_log  [0:40];
  logic       err_log   [0:40];
  logic       ready_log [0:40];

  always #5 clk = ~clk;

  fractcam_writer #(.TCAM_WIDTH(5), .TCAM_DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .s_wr_valid(wr_valid), .s_wr_ready(wr_ready), .s_wr_index(wr_index),
    .s_wr_value(wr_value), .s_wr_mask(wr_mask), .s_wr_entry_en(wr_en),
    .wr_done(wr_done), .wr_err(wr_err), .busy(busy),
    .lookup_key(lookup_key), .tcam_search_key(skey),
    .tcam_wr_enable(wen), .tcam_rules(rules)
  );

  fractcam_writer #(.TCAM_WIDTH(5), .TCAM_DEPTH(40)) dut40 (
    .clk(clk), .rst(rst),
    .s_wr_valid(b_valid), .s_wr_ready(b_ready), .s_wr_index(b_index),
    .s_wr_value(b_value), .s_wr_mask(b_mask), .s_wr_entry_en(b_en),
    .wr_done(b_done), .wr_err(b_err), .busy(b_busy),
    .lookup_key(b_lookup), .tcam_search_key(b_skey),
    .tcam_wr_enable(b_wen), .tcam_rules(b_rules)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake during cycle 0, then capture cycles 1..36.
  task automatic run_write(input logic [5:0] idx, input logic [4:0] v,
                           input logic [4:0] m, input logic e);
    wr_index = idx; wr_value = v; wr_mask = m; wr_en = e; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; wr_index = '0; wr_value = '0; wr_mask = '0; wr_en = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      if (n > 1) tick();
      wen_log[n] = wen; rules_log[n] = rules; key_log[n] = skey;
      done_log[n] = wr_done; err_log[n] = wr_err; ready_log[n] = wr_ready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 0; wr_index = 0; wr_value = 0; wr_mask = 0; wr_en = 0; lookup_key = 0;
    b_valid = 0; b_index = 0; b_value = 0; b_mask = 0; b_en = 0; b_lookup = 0;
    tick(); tick();
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    total++; if (wen !== 8'h00) begin bad++; $display("FAIL reset_wen got=%h exp=00", wen); end
    total++; if (rules !== 8'h00) begin bad++; $display("FAIL reset_rules got=%h exp=00", rules); end
    total++; if ({wr_done, wr_err} !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", {wr_done, wr_err}); end
    total++; if (skey !== 5'h00) begin bad++; $display("FAIL reset_key got=%h exp=00", skey); end
    rst = 1'b0;
  endtask

  task automatic test_flush(input string tag);
    for (int n = 1; n <= 33; n++) begin
      tick();
      total++;
      if (wen !== ((n <= 32) ? 8'hFF : 8'h00)) begin
        bad++; $display("FAIL %s_wen cyc=%0d got=%h", tag, n, wen);
      end
      total++;
      if (rules !== 8'h00 || wr_done !== 1'b0) begin
        bad++; $display("FAIL %s_rules cyc=%0d got=%h done=%b exp=00/0", tag, n, rules, wr_done);
      end
      total++;
      if (wr_ready !== (n == 33)) begin
        bad++; $display("FAIL %s_ready cyc=%0d got=%b", tag, n, wr_ready);
      end
      if (n <= 32) begin
        total++;
        if (skey !== 5'(n - 1)) begin
          bad++; $display("FAIL %s_key cyc=%0d got=%h exp=%h", tag, n, skey, 5'(n - 1));
        end
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b exp=0", tag, busy); end
  endtask

  // Common check of a captured group sweep against a caller-supplied rule table.
  task automatic test_sweep(input string tag, input logic [7:0] exp_wen,
                            input logic [7:0] exp_rules [0:31]);
    for (int n = 1; n <= 35; n++) begin
      logic [7:0] ew, er;
      ew = (n >= 2 && n <= 33) ? exp_wen : 8'h00;
      er = (n >= 2 && n <= 33) ? exp_rules[n-2] : 8'h00;
      total++;
      if (wen_log[n] !== ew || rules_log[n] !== er) begin
        bad++; $display("FAIL %s_strobe cyc=%0d wen=%h rules=%h exp=%h/%h", tag, n, wen_log[n], rules_log[n], ew, er);
      end
      total++;
      if (done_log[n] !== (n == 34) || err_log[n] !== 1'b0 || ready_log[n] !== (n == 35)) begin
        bad++; $display("FAIL %s_ctrl cyc=%0d done=%b err=%b ready=%b", tag, n, done_log[n], err_log[n], ready_log[n]);
      end
      if (n >= 2 && n <= 33) begin
        total++;
        if (key_log[n] !== 5'(n - 2)) begin
          bad++; $display("FAIL %s_key cyc=%0d got=%h exp=%h", tag, n, key_log[n], 5'(n - 2));
        end
      end
    end
  endtask

  task automatic test_exact();
    logic [7:0] er [0:31];
    for (int a = 0; a < 32; a++) er[a] = (a == 10) ? 8'h08 : 8'h00;
    run_write(6'd3, 5'h0A, 5'h1F, 1'b1);
    test_sweep("exact", 8'h01, er);
  endtask

  task automatic test_lookup();
    lookup_key = 5'h0A;
    tick();
    total++; if (skey !== 5'h0A) begin bad++; $display("FAIL lookup_key got=%h exp=0a", skey); end
    lookup_key = 5'h17;
    #1;
    total++; if (skey !== 5'h0A) begin bad++; $display("FAIL lookup_hold got=%h exp=0a", skey); end
    tick();
    total++; if (skey !== 5'h17) begin bad++; $display("FAIL lookup_key2 got=%h exp=17", skey); end
  endtask

  task automatic test_wildcard();
    logic [7:0] er [0:31];
    for (int a = 0; a < 32; a++) er[a] = (a >= 16) ? 8'h02 : 8'h00;
    run_write(6'd9, 5'h10, 5'h10, 1'b1);
    test_sweep("wild", 8'h02, er);
  endtask

  task automatic test_delete();
    logic [7:0] er [0:31];
    for (int a = 0; a < 32; a++) er[a] = 8'h00;
    run_write(6'd3, 5'h0A, 5'h1F, 1'b0);
    test_sweep("delete", 8'h01, er);
    // Neighbour in group 1: entry 9 must survive alongside new entry 10.
    for (int a = 0; a < 32; a++) er[a] = ((a >= 16) ? 8'h02 : 8'h00) | ((a == 3) ? 8'h04 : 8'h00);
    run_write(6'd10, 5'h03, 5'h1F, 1'b1);
    test_sweep("neigh", 8'h02, er);
  endtask

  task automatic test_backpressure();
    b_index = 6'd39; b_value = 5'h00; b_mask = 5'h00; b_en = 1'b1; b_valid = 1'b1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", b_ready); end
    tick();
    b_index = 6'd45;
    for (int n = 1; n <= 38; n++) begin
      if (n > 1) tick();
      total++;
      if (b_ready !== (n == 35 || n == 38)) begin
        bad++; $display("FAIL bp_ready cyc=%0d got=%b", n, b_ready);
      end
      total++;
      if (b_wen !== ((n >= 2 && n <= 33) ? 5'h10 : 5'h00) ||
          b_rules !== ((n >= 2 && n <= 33) ? 8'h80 : 8'h00)) begin
        bad++; $display("FAIL bp_strobe cyc=%0d wen=%h rules=%h", n, b_wen, b_rules);
      end
      total++;
      if (b_done !== (n == 34 || n == 37) || b_err !== (n == 37)) begin
        bad++; $display("FAIL bp_done cyc=%0d done=%b err=%b", n, b_done, b_err);
      end
      if (n == 36) b_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] er [0:31];
    wr_index = 6'd3; wr_value = 5'h0A; wr_mask = 5'h1F; wr_en = 1'b1; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    for (int n = 2; n <= 17; n++) tick();
    total++;
    if (wen !== 8'h01 || skey !== 5'd15) begin
      bad++; $display("FAIL mid_pre wen=%h key=%h exp=01/0f", wen, skey);
    end
    rst = 1'b1;
    #1;
    total++;
    if (wen !== 8'h00 || rules !== 8'h00 || skey !== 5'h00) begin
      bad++; $display("FAIL mid_rst_data wen=%h rules=%h key=%h exp=0", wen, rules, skey);
    end
    total++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || wr_done !== 1'b0 || wr_err !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctrl busy=%b ready=%b done=%b err=%b", busy, wr_ready, wr_done, wr_err);
    end
    tick();
    rst = 1'b0;
    test_flush("reflush");
    // Shadow was cleared: group 1 sweep must no longer carry entries 9/10.
    for (int a = 0; a < 32; a++) er[a] = 8'h00;
    run_write(6'd8, 5'h00, 5'h00, 1'b0);
    test_sweep("cleared", 8'h02, er);
  endtask

  initial begin
    test_reset();
    test_flush("flush");
    test_exact();
    test_lookup();
    test_wildcard();
    test_delete();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
